// File: rtl/fetch_stage_if.sv
// Bundle of the fetch-stage handshake: hazard controls and redirects in, fetch address and IF/ID contents out.
// The master side is the pipeline/hazard logic and instruction memory; the slave side is fetch_stage.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;

  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD
  );

  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter plus the IF/ID pipeline register,
// with load-use stalls, Execute-resolved redirects and decode-slot flushing.
module fetch_stage #(
  parameter int                        DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0]     NOP_INSTR  = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcd_q, pcd_d;
  logic [DATA_WIDTH-1:0] pc_plus4d_q, pc_plus4d_d;
  logic                  valid_q, valid_d;

  // A redirect beats a stall so a resolved branch is never dropped;
  // likewise a flush beats a decode stall.
  always_comb begin
    pc_plus4_f = pc_q + DATA_WIDTH'(4);
    pc_d       = pc_plus4_f;
    if (bus.PCSrcE) begin
      pc_d = bus.PCTargetE & ALIGN_MASK;
    end else if (bus.StallF) begin
      pc_d = pc_q;
    end

    instr_d     = instr_q;
    pcd_d       = pcd_q;
    pc_plus4d_d = pc_plus4d_q;
    valid_d     = valid_q;
    if (bus.FlushD) begin
      instr_d     = NOP_INSTR;
      pcd_d       = '0;
      pc_plus4d_d = '0;
      valid_d     = 1'b0;
    end else if (!bus.StallD) begin
      instr_d     = bus.InstrF;
      pcd_d       = pc_q;
      pc_plus4d_d = pc_plus4_f;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pcd_q       <= '0;
      pc_plus4d_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pc_plus4d_q <= pc_plus4d_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.PCF      = pc_q;
  assign bus.InstrD   = instr_q;
  assign bus.PCD      = pcd_q;
  assign bus.PCPlus4D = pc_plus4d_q;
  assign bus.ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect/flush
// traffic, all compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;
  localparam int          DW        = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fetch_stage_if #(.DATA_WIDTH(DW)) bus ();

  fetch_stage #(
    .DATA_WIDTH(DW),
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction memory returns an address-tagged word that can never equal the NOP.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0000;
  endfunction

  assign bus.InstrF = imem(bus.PCF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what each output should hold in the current cycle.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  logic        m_valid;

  task automatic modelReset();
    m_pc    = RESET_PC;
    m_instr = NOP_INSTR;
    m_pcd   = 32'h0;
    m_pc4d  = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic modelStep(input logic sf, input logic sd, input logic fd,
                           input logic ps, input logic [31:0] tgt);
    logic [31:0] next_pc;
    if (ps)      next_pc = {tgt[31:2], 2'b00};
    else if (sf) next_pc = m_pc;
    else         next_pc = m_pc + 32'd4;
    if (fd) begin
      m_instr = NOP_INSTR; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
    end else if (!sd) begin
      m_instr = imem(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1'b1;
    end
    m_pc = next_pc;
  endtask

  task automatic checkOutput(input string tag);
    tests++;
    assert (bus.PCF === m_pc) else begin
      fails++; $error("[TB] FAIL %s PCF observed=%h expected=%h", tag, bus.PCF, m_pc);
    end
    tests++;
    assert (bus.InstrD === m_instr) else begin
      fails++; $error("[TB] FAIL %s InstrD observed=%h expected=%h", tag, bus.InstrD, m_instr);
    end
    tests++;
    assert (bus.PCD === m_pcd) else begin
      fails++; $error("[TB] FAIL %s PCD observed=%h expected=%h", tag, bus.PCD, m_pcd);
    end
    tests++;
    assert (bus.PCPlus4D === m_pc4d) else begin
      fails++; $error("[TB] FAIL %s PCPlus4D observed=%h expected=%h", tag, bus.PCPlus4D, m_pc4d);
    end
    tests++;
    assert (bus.ValidD === m_valid) else begin
      fails++; $error("[TB] FAIL %s ValidD observed=%h expected=%h", tag, bus.ValidD, m_valid);
    end
  endtask

  // Drive one cycle of controls from a negedge, advance the model at the edge, check at the next negedge.
  task automatic applyStimulus(input string tag, input logic sf, input logic sd, input logic fd,
                               input logic ps, input logic [31:0] tgt);
    bus.StallF    = sf;
    bus.StallD    = sd;
    bus.FlushD    = fd;
    bus.PCSrcE    = ps;
    bus.PCTargetE = tgt;
    @(posedge clk);
    modelStep(sf, sd, fd, ps, tgt);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    logic        r_sf, r_sd, r_fd, r_ps;
    logic [31:0] r_tgt;
    tests = 0;
    fails = 0;
    rst           = 1'b1;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.PCSrcE    = 1'b0;
    bus.PCTargetE = 32'h0;
    modelReset();

    #3;
    checkOutput("reset_async");
    @(negedge clk);
    checkOutput("reset_held");
    rst = 1'b0;

    // Sequential fetch from RESET_PC up to PCF = 0x10
    for (int i = 0; i < 4; i++) applyStimulus("seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Three-cycle load-use stall, then resume
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus("resume", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect with flush at PCF = 0x20 to a misaligned target
    applyStimulus("redirect", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    applyStimulus("after_redirect", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("target_in_decode", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Priority: redirect over StallF, flush over StallD
    applyStimulus("prio", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0204);
    applyStimulus("prio_next", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Wrap at the top of the address space
    applyStimulus("wrap_redirect", 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    applyStimulus("wrap_pc", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("wrap_decode", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset between edges while stalled
    applyStimulus("pre_reset_stall", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'h0000_0400;
    #1 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_midrun");
    @(negedge clk);
    checkOutput("reset_midrun_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("restart", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r_sf  = ($urandom_range(0, 3) == 0);
      r_sd  = ($urandom_range(0, 1) == 0) ? r_sf : ($urandom_range(0, 4) == 0);
      r_ps  = ($urandom_range(0, 6) == 0);
      r_fd  = r_ps ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      r_tgt = $urandom;
      applyStimulus("random", r_sf, r_sd, r_fd, r_ps, r_tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
